// File: rtl/sub_serial_if.sv
// Operand/result bundle for the bit-serial subtractor; the master drives start and operands,
// the slave returns difference, borrow and status.
interface sub_serial_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             borrow;
    logic             busy;
    logic             done;

    modport master (
        output en, a, b,
        input  out, borrow, busy, done
    );

    modport slave (
        input  en, a, b,
        output out, borrow, busy, done
    );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial 2's-complement subtractor, out = a - b LSB-first with a ripple borrow register.
// Latency WIDTH+1 clocks start-to-done; en is ignored while busy, and DONE restarts back-to-back.
module sub_serial #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    sub_serial_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2,
        ILL  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               borrow_q, borrow_d;
    logic               brw_q, brw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               d_bit;
    logic               brw_nxt;

    assign d_bit   = a_q[0] ^ b_q[0] ^ brw_q;
    assign brw_nxt = (~a_q[0] & b_q[0]) | (~a_q[0] & brw_q) | (b_q[0] & brw_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            borrow_q <= 1'b0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            borrow_q <= borrow_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        borrow_d = borrow_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.en) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    out_d    = '0;
                    brw_d    = 1'b0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SUB;
                end
            end
            SUB: begin
                // Difference bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts
                out_d = {d_bit, out_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                brw_d = brw_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    borrow_d = brw_nxt;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out    = out_q;
    assign bus.borrow = borrow_q;
    assign bus.busy   = (state_q == SUB);
    assign bus.done   = (state_q == DONE);
endmodule

// File: tb/tb_sub_serial.sv
// Directed and randomized checks of sub_serial against an arithmetic reference (a - b, a < b).
module tb_sub_serial;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    sub_serial_if #(.WIDTH(8)) bus ();

    sub_serial #(.WIDTH(8), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ref_sub(input logic [7:0] av, input logic [7:0] bv);
        int diff;
        diff = int'(av) - int'(bv);
        ref_sub = {(av < bv), 8'(diff)};
    endfunction

    // Start at a negedge, count busy cycles, then check the result once done rises.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input string tag,
                          input bit scramble);
        int         busy_n;
        bit         seen;
        logic [8:0] exp;
        exp = ref_sub(av, bv);
        @(negedge clk);
        bus.en = 1'b1; bus.a = av; bus.b = bv;
        @(negedge clk);
        bus.en = 1'b0;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.done) seen = 1'b1;
            else begin
                if (bus.busy) busy_n++;
                if (scramble) begin
                    bus.en = 1'($urandom);
                    bus.a  = 8'($urandom);
                    bus.b  = 8'($urandom);
                end
                @(negedge clk);
            end
        end
        bus.en = 1'b0;
        chk({tag, "_done"},   32'(seen), 32'd1);
        chk({tag, "_busy"},   32'(busy_n), 32'd8);
        chk({tag, "_out"},    32'(bus.out), 32'(exp[7:0]));
        chk({tag, "_borrow"}, 32'(bus.borrow), 32'(exp[8]));
    endtask

    initial begin
        logic [7:0] qa [4];
        logic [7:0] qb [4];
        logic [8:0] exp;
        logic [7:0] hold_out;
        logic       hold_brw;
        bit         stable;

        rst = 1'b0; bus.en = 1'b0; bus.a = '0; bus.b = '0;
        #3;
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_borrow", 32'(bus.borrow), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        #9 rst = 1'b1;

        run_op(8'h5A, 8'h23, "t1", 1'b0);
        run_op(8'h10, 8'h20, "t2a", 1'b0);
        run_op(8'h00, 8'h01, "t2b", 1'b0);
        run_op(8'hFF, 8'hFF, "t3a", 1'b0);
        run_op(8'h80, 8'h7F, "t3b", 1'b0);
        run_op(8'hC3, 8'h3C, "t4", 1'b1);
        @(negedge clk);
        chk("t4_norestart", 32'(bus.done), 32'd1);
        chk("t4_hold", 32'(bus.out), 32'h87);

        for (int i = 0; i < 12; i++) begin
            run_op(8'($urandom), 8'($urandom), "rnd", 1'b0);
        end

        // Back-to-back: en held high, next operands presented while done is high
        for (int i = 0; i < 4; i++) begin
            qa[i] = 8'($urandom);
            qb[i] = 8'($urandom);
        end
        @(negedge clk);
        bus.en = 1'b1; bus.a = qa[0]; bus.b = qb[0];
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            int busy_n;
            busy_n = 0;
            for (int c = 0; c < 8; c++) begin
                if (bus.busy) busy_n++;
                @(negedge clk);
            end
            exp = ref_sub(qa[i], qb[i]);
            chk("b2b_busy", 32'(busy_n), 32'd8);
            chk("b2b_done", 32'(bus.done), 32'd1);
            chk("b2b_out", 32'(bus.out), 32'(exp[7:0]));
            chk("b2b_borrow", 32'(bus.borrow), 32'(exp[8]));
            if (i < 3) begin
                bus.a = qa[i+1]; bus.b = qb[i+1];
            end else begin
                bus.en = 1'b0;
            end
            @(negedge clk);
            if (i < 3) chk("b2b_restart", 32'(bus.busy), 32'd1);
        end
        hold_out = bus.out;
        hold_brw = bus.borrow;
        stable   = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (!bus.done || bus.out !== hold_out || bus.borrow !== hold_brw) stable = 1'b0;
            bus.a = 8'($urandom); bus.b = 8'($urandom);
            @(negedge clk);
        end
        chk("idle_stable", 32'(stable), 32'd1);
        chk("idle_out", 32'(hold_out), 32'(exp[7:0]));

        // Asynchronous reset mid-operation, between clock edges
        @(negedge clk);
        bus.en = 1'b1; bus.a = 8'h5A; bus.b = 8'h23;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_out", 32'(bus.out), 32'd0);
        chk("arst_borrow", 32'(bus.borrow), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(8'h01, 8'h01, "t6", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
Bit-serial 2's-complement subtractor. It computes out = a - b LSB-first, one bit per clock, using a ripple borrow register, and is the inverse operator of the team's bit-serial adder. It uses the same start/done control style so the two blocks can be swapped in the same datapath slot. It sits between an operand register file and a result consumer that samples out when done is high.

Parameters:
WIDTH, 8, operand and result width in bits (WIDTH >= 2)
CNT_W, 3, bit-counter width; must satisfy 2**CNT_W >= WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
en  input  1  start request; sampled only in IDLE and DONE
a  input  WIDTH  minuend; captured on an accepted start
b  input  WIDTH  subtrahend; captured on an accepted start
out  output  WIDTH  difference; valid while done=1
borrow  output  1  borrow-out of the MSB (1 when a < b unsigned); valid while done=1
busy  output  1  high while in SUB
done  output  1  high while in DONE

Behaviour:
- Reset (rst=0, asynchronous, takes effect without a clock edge): state=IDLE, out=0, borrow=0, a_reg=0, b_reg=0, brw=0, count=0, busy=0, done=0. Reset can arrive mid-operation; the operation is abandoned and no partial result is retained.
- State encoding: IDLE=2'd0, SUB=2'd1, DONE=2'd2. Code 2'd3 is illegal and returns to IDLE on the next edge with all registers left unchanged.
- busy = (state==SUB) and done = (state==DONE), both decoded combinationally from the state register.
- IDLE:
  - en=1 loads a_reg<=a, b_reg<=b, out<=0, brw<=0, borrow<=0, count<=0, and moves to SUB.
  - en=0 holds IDLE and all registers.
- SUB, on every edge:
  - d = a_reg[0] ^ b_reg[0] ^ brw
  - brw <= (~a_reg[0] & b_reg[0]) | (~a_reg[0] & brw) | (b_reg[0] & brw)
  - out <= {d, out[WIDTH-1:1]}
  - a_reg <= a_reg>>1, b_reg <= b_reg>>1, count <= count+1
  - When count==WIDTH-1: borrow <= next-brw value and state moves to DONE. Otherwise state stays in SUB.
  - en, a and b are ignored in SUB.
- DONE:
  - out and borrow hold.
  - en=1 performs the same load as IDLE and goes directly to SUB, giving back-to-back operation with no idle cycle.
  - en=0 stays in DONE indefinitely.
- Latency: with a start accepted at edge k, SUB covers edges k+1..k+WIDTH and done=1 after edge k+WIDTH. That is WIDTH+1 clocks from start to done, and the throughput is one result per WIDTH+1 clocks.
- Arithmetic is modulo 2**WIDTH. The result is correct for both unsigned and 2's-complement inputs; borrow is the unsigned-compare flag. There is no overflow output.
- Input changes after the start edge must not affect the result.

Test Plan:
1. Reset, then a=8'h5A, b=8'h23, en pulsed 1 cycle -> busy high 8 cycles; done=1 on the 9th edge after the start; out=8'h37, borrow=0.
2. a=8'h10, b=8'h20 -> out=8'hF0, borrow=1. Then a=8'h00, b=8'h01 -> out=8'hFF, borrow=1.
3. a=8'hFF, b=8'hFF -> out=8'h00, borrow=0. Then a=8'h80, b=8'h7F -> out=8'h01, borrow=0.
4. Start a=8'hC3, b=8'h3C; during SUB toggle en and change a/b to random values every cycle -> out=8'h87, borrow=0; no restart.
5. Hold en=1 continuously with new operands presented at each DONE -> results arrive every 9 cycles with no IDLE cycle; each result is correct. Then en=0 for 20 cycles -> done and out stable.
6. Start a=8'h5A, b=8'h23, drive rst=0 asynchronously (between edges) when count=4 -> out, borrow, busy, done go to 0 immediately. Release rst, run a=8'h01, b=8'h01 -> out=8'h00, borrow=0.
